// File: rtl/prty_gen.sv
// prty_gen: even-parity generator for wide datapaths.
// Appends one even-parity bit per CELL_WTH-bit cell above the payload,
// through a two-stage valid/ready pipeline. A one-shot error-injection
// facility inverts parity[0] of a single beat so the downstream checker
// can be exercised.
module prty_gen #(
    parameter  int DATA_WTH = 531,
    parameter  int CELL_WTH = 64,
    parameter  int CNT_WTH  = 16,
    localparam int PRTY_WTH = (DATA_WTH + CELL_WTH - 1) / CELL_WTH,
    localparam int OUT_WTH  = DATA_WTH + PRTY_WTH
) (
    input  logic                clks,
    input  logic                rst_n,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [DATA_WTH-1:0] in_data,
    input  logic                err_inj,
    output logic                err_inj_pend,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [OUT_WTH-1:0]  out_data,
    output logic [CNT_WTH-1:0]  inj_cnt
);

    // Payload zero-extended to a whole number of cells, so a short last cell
    // simply XORs in zeros above DATA_WTH.
    localparam int PAD_WTH = PRTY_WTH * CELL_WTH;

    // Even parity of every cell; parity bit i covers cell i.
    function automatic logic [PRTY_WTH-1:0] cell_prty(input logic [DATA_WTH-1:0] data);
        logic [PAD_WTH-1:0]  pad;
        logic [PRTY_WTH-1:0] prty;
        pad  = PAD_WTH'(data);
        prty = {PRTY_WTH{1'b0}};
        for (int i = 0; i < PRTY_WTH; i++) begin
            prty[i] = ^pad[i*CELL_WTH +: CELL_WTH];
        end
        return prty;
    endfunction

    // Stage 1 state
    logic                s1_vld_r;
    logic [DATA_WTH-1:0] s1_data_r;
    logic [PRTY_WTH-1:0] s1_prty_r;
    logic                s1_inj_r;

    // Stage 2 (output) state
    logic                out_vld_r;
    logic [OUT_WTH-1:0]  out_data_r;
    logic                out_inj_r;

    // Injection bookkeeping
    logic                pend_r;
    logic [CNT_WTH-1:0]  inj_cnt_r;

    // Handshake terms
    logic                s2_move_s;
    logic                s1_move_s;
    logic                accept_s;
    logic                inj_s;
    logic [PRTY_WTH-1:0] inj_mask_s;
    logic                cnt_inc_s;

    assign s2_move_s  = out_vld_r && out_rdy;
    // Stage 1 advances when stage 2 is empty or draining this cycle.
    assign s1_move_s  = s1_vld_r && (!out_vld_r || s2_move_s);
    assign in_rdy     = !s1_vld_r || s1_move_s;
    assign accept_s   = in_vld && in_rdy;
    // A pulse coinciding with an accept injects that very beat.
    assign inj_s      = pend_r || err_inj;
    assign inj_mask_s = {{(PRTY_WTH-1){1'b0}}, inj_s};
    assign cnt_inc_s  = s2_move_s && out_inj_r && (inj_cnt_r != {CNT_WTH{1'b1}});

    assign err_inj_pend = pend_r;
    assign out_vld      = out_vld_r;
    assign out_data     = out_data_r;
    assign inj_cnt      = inj_cnt_r;

    // Valid flags for both stages; a stage refills when it is empty or moving.
    always_ff @(posedge clks or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r  <= 1'b0;
            out_vld_r <= 1'b0;
        end else begin
            if (accept_s) begin
                s1_vld_r <= 1'b1;
            end else if (s1_move_s) begin
                s1_vld_r <= 1'b0;
            end else begin
                s1_vld_r <= s1_vld_r;
            end

            if (s1_move_s) begin
                out_vld_r <= 1'b1;
            end else if (s2_move_s) begin
                out_vld_r <= 1'b0;
            end else begin
                out_vld_r <= out_vld_r;
            end
        end
    end

    // Datapath registers; contents only matter while the matching valid is set.
    always_ff @(posedge clks) begin
        if (accept_s) begin
            s1_data_r <= in_data;
            s1_prty_r <= cell_prty(in_data) ^ inj_mask_s;
            s1_inj_r  <= inj_s;
        end
        if (s1_move_s) begin
            out_data_r <= {s1_prty_r, s1_data_r};
            out_inj_r  <= s1_inj_r;
        end
    end

    // One-shot injection arm and saturating count of injected beats sent.
    always_ff @(posedge clks or negedge rst_n) begin
        if (!rst_n) begin
            pend_r    <= 1'b0;
            inj_cnt_r <= {CNT_WTH{1'b0}};
        end else begin
            if (accept_s) begin
                pend_r <= 1'b0;
            end else if (err_inj) begin
                pend_r <= 1'b1;
            end else begin
                pend_r <= pend_r;
            end

            if (cnt_inc_s) begin
                inj_cnt_r <= inj_cnt_r + {{(CNT_WTH-1){1'b0}}, 1'b1};
            end else begin
                inj_cnt_r <= inj_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_prty_gen.sv
// tb_prty_gen: table-driven vectors plus scoreboard monitor for prty_gen.
module tb_prty_gen;

    localparam int DW = 531;
    localparam int CW = 64;
    localparam int PW = 9;
    localparam int OW = 540;
    localparam int NW = 16;

    logic          clks = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] in_data;
    logic          err_inj;
    logic          err_inj_pend;
    logic          out_vld;
    logic          out_rdy;
    logic [OW-1:0] out_data;
    logic [NW-1:0] inj_cnt;

    always #5 clks = ~clks;

    prty_gen dut (
        .clks         (clks),
        .rst_n        (rst_n),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_data      (in_data),
        .err_inj      (err_inj),
        .err_inj_pend (err_inj_pend),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_data     (out_data),
        .inj_cnt      (inj_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          inj;
    } beat_t;

    typedef struct {
        string         name;
        logic [DW-1:0] data;
        logic [PW-1:0] prty;
    } vec_t;

    beat_t         sb_q[$];
    int            checks = 0;
    int            errors = 0;
    int            emit_cnt = 0;
    logic          pend_m = 1'b0;
    logic [NW-1:0] cnt_m = '0;
    logic          stall_m = 1'b0;
    logic [OW-1:0] stall_data_m;

    // Reference parity: shift each cell down to bit 0 and reduce its low CW bits.
    function automatic logic [PW-1:0] ref_prty(input logic [DW-1:0] d);
        logic [DW-1:0] t;
        logic [PW-1:0] p;
        for (int i = 0; i < PW; i++) begin
            t    = d >> (i * CW);
            p[i] = ^t[CW-1:0];
        end
        return p;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [575:0] w;
        for (int k = 0; k < 18; k++) w[k*32 +: 32] = $urandom;
        return w[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] onehot(input int n);
        logic [DW-1:0] d;
        d    = '0;
        d[n] = 1'b1;
        return d;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clks);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        out_rdy = 1'b1;
        n = 0;
        while ((sb_q.size() != 0 || out_vld) && n < 50) begin
            step();
            n++;
        end
        check_int(name, sb_q.size(), 0);
    endtask

    // Scoreboard monitor, evaluated on the falling edge while inputs are stable.
    always @(negedge clks) begin
        beat_t b;
        logic  chk;
        if (!rst_n) begin
            sb_q.delete();
            pend_m  = 1'b0;
            cnt_m   = '0;
            stall_m = 1'b0;
        end else begin
            check_bit("err_inj_pend", err_inj_pend, pend_m);
            check_int("inj_cnt", int'(inj_cnt), int'(cnt_m));
            if (stall_m) begin
                check_bit("stall_vld", out_vld, 1'b1);
                check_wide("stall_data", out_data, stall_data_m);
            end
            if (out_vld && out_rdy) begin
                emit_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got beat %0h expected none", out_data);
                end else begin
                    b = sb_q.pop_front();
                    check_wide("out_data", out_data,
                               {ref_prty(b.data) ^ {{(PW-1){1'b0}}, b.inj}, b.data});
                    chk = |(ref_prty(out_data[DW-1:0]) ^ out_data[OW-1:DW]);
                    check_bit("chk_rsult", chk, b.inj);
                    if (b.inj && cnt_m != '1) cnt_m = cnt_m + 16'd1;
                end
            end
            stall_m      = out_vld && !out_rdy;
            stall_data_m = out_data;
            if (in_vld && in_rdy) begin
                sb_q.push_back('{data: in_data, inj: pend_m || err_inj});
                pend_m = 1'b0;
            end else if (err_inj) begin
                pend_m = 1'b1;
            end
        end
    end

    vec_t vecs[9];

    initial begin
        int            sent;
        int            cyc;
        int            acc_n;
        int            emit_before;
        logic          acc;
        logic [DW-1:0] all1;

        all1 = '1;
        vecs[0] = '{name: "vec_zero",   data: '0,                          prty: 9'h000};
        vecs[1] = '{name: "vec_bit0",   data: onehot(0),                   prty: 9'h001};
        vecs[2] = '{name: "vec_bit530", data: onehot(530),                 prty: 9'h100};
        vecs[3] = '{name: "vec_bit512", data: onehot(512),                 prty: 9'h100};
        vecs[4] = '{name: "vec_bit511", data: onehot(511),                 prty: 9'h080};
        vecs[5] = '{name: "vec_bit64",  data: onehot(64),                  prty: 9'h002};
        vecs[6] = '{name: "vec_bit0_1", data: onehot(0) | onehot(1),       prty: 9'h000};
        vecs[7] = '{name: "vec_ones",   data: all1,                        prty: 9'h100};
        vecs[8] = '{name: "vec_63_64",  data: onehot(63) | onehot(64),     prty: 9'h003};

        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        err_inj = 1'b0;
        out_rdy = 1'b1;
        step();
        step();
        check_bit("rst_out_vld", out_vld, 1'b0);
        check_bit("rst_in_rdy", in_rdy, 1'b1);
        check_bit("rst_pend", err_inj_pend, 1'b0);
        check_int("rst_inj_cnt", int'(inj_cnt), 0);
        rst_n = 1'b1;
        step();
        check_bit("post_rst_in_rdy", in_rdy, 1'b1);

        // Latency: accept at one edge, out_vld two edges later.
        in_data = '0;
        in_vld  = 1'b1;
        step();
        in_vld = 1'b0;
        check_bit("lat_1_vld", out_vld, 1'b0);
        step();
        check_bit("lat_2_vld", out_vld, 1'b1);
        check_wide("lat_2_data", out_data, '0);
        step();

        // Parity placement table.
        for (int i = 0; i < 9; i++) begin
            in_data = vecs[i].data;
            in_vld  = 1'b1;
            step();
            in_vld = 1'b0;
            step();
            check_bit({vecs[i].name, "_vld"}, out_vld, 1'b1);
            check_wide({vecs[i].name, "_prty"}, OW'(out_data[OW-1:DW]), OW'(vecs[i].prty));
            check_wide({vecs[i].name, "_payload"}, OW'(out_data[DW-1:0]), OW'(vecs[i].data));
            step();
        end

        // Random stream with random backpressure.
        sent = 0;
        cyc  = 0;
        while (sent < 20 && cyc < 500) begin
            out_rdy = 1'($urandom_range(0, 1));
            if (!in_vld) begin
                in_vld  = 1'b1;
                in_data = rand_data();
            end
            #1;
            acc = in_rdy;
            step();
            cyc++;
            if (acc) begin
                sent++;
                in_vld = 1'b0;
            end
        end
        in_vld = 1'b0;
        check_int("rand_sent", sent, 20);
        drain("rand_drain");

        // Sustained full rate with out_rdy held high.
        out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_vld  = 1'b1;
            in_data = rand_data();
            #1;
            check_bit("full_rate_rdy", in_rdy, 1'b1);
            step();
        end
        in_vld = 1'b0;
        drain("full_rate_drain");

        // Backpressure: two beats fill the pipe, the third waits.
        out_rdy = 1'b0;
        acc_n   = 0;
        in_vld  = 1'b1;
        in_data = rand_data();
        for (int k = 0; k < 5; k++) begin
            #1;
            acc = in_rdy;
            step();
            if (acc) begin
                acc_n++;
                in_data = rand_data();
            end
        end
        check_int("bp_accepted", acc_n, 2);
        check_bit("bp_in_rdy", in_rdy, 1'b0);
        out_rdy = 1'b1;
        #1;
        check_bit("bp_release_rdy", in_rdy, 1'b1);
        cyc = 0;
        while (acc_n < 3 && cyc < 10) begin
            acc = in_rdy;
            step();
            cyc++;
            if (acc) acc_n++;
            #1;
        end
        in_vld = 1'b0;
        check_int("bp_third", acc_n, 3);
        drain("bp_drain");

        // Error injection: arm with no input, double pulse arms only once.
        err_inj = 1'b1;
        step();
        err_inj = 1'b0;
        check_bit("inj_pend_set", err_inj_pend, 1'b1);
        err_inj = 1'b1;
        step();
        err_inj = 1'b0;
        check_bit("inj_pend_hold", err_inj_pend, 1'b1);
        in_data = '0;
        in_vld  = 1'b1;
        step();
        in_vld = 1'b0;
        check_bit("inj_pend_clr", err_inj_pend, 1'b0);
        step();
        check_wide("inj_data", out_data, {9'h001, {DW{1'b0}}});
        step();
        check_int("inj_cnt_1", int'(inj_cnt), 1);
        // Next beat is clean.
        in_data = '0;
        in_vld  = 1'b1;
        step();
        in_vld = 1'b0;
        step();
        check_wide("inj_oneshot", out_data, '0);
        step();
        check_int("inj_cnt_still1", int'(inj_cnt), 1);
        // Pulse coinciding with an accept injects that beat directly.
        err_inj = 1'b1;
        in_data = onehot(5);
        in_vld  = 1'b1;
        step();
        err_inj = 1'b0;
        in_vld  = 1'b0;
        check_bit("inj_coinc_pend", err_inj_pend, 1'b0);
        step();
        check_wide("inj_coinc_data", out_data, {9'h000, onehot(5)});
        step();
        check_int("inj_cnt_2", int'(inj_cnt), 2);

        // Reset mid-stream with both stages full.
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_data = rand_data();
        step();
        in_data = rand_data();
        step();
        in_vld = 1'b0;
        check_bit("mid_full_vld", out_vld, 1'b1);
        check_bit("mid_full_rdy", in_rdy, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("mid_rst_vld", out_vld, 1'b0);
        check_int("mid_rst_cnt", int'(inj_cnt), 0);
        step();
        step();
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        emit_before = emit_cnt;
        repeat (4) step();
        check_int("mid_no_stale", emit_cnt, emit_before);
        check_bit("mid_post_vld", out_vld, 1'b0);
        check_int("mid_post_cnt", int'(inj_cnt), 0);

        drain("final_drain");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
